// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// FSM state encoding, XZR index and scoreboard entry layout.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  localparam int SB_W = $bits(sb_entry_t);

  function automatic logic sb_hit(
    input sb_entry_t  e,
    input logic [4:0] r
  );
    return e.valid && (e.rd == r);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// 3-entry shift scoreboard (EX/MEM/WB destinations) and RAW match.
// Ports: CLK/resetl, flush, issue, ID operand fields -> hazard, empty.
module pipe_hazard_ctrl_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic       CLK,
  input  logic       resetl,
  input  logic       flush,
  input  logic       issue,
  input  logic       id_valid,
  input  logic [4:0] id_rs_a,
  input  logic       id_rs_a_used,
  input  logic [4:0] id_rs_b,
  input  logic       id_rs_b_used,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  output logic       hazard,
  output logic       empty
);

  sb_entry_t sb_ex, sb_mem, sb_wb;
  sb_entry_t new_ent;
  logic      match_a, match_b;

  always_comb begin
    new_ent       = '0;
    new_ent.valid = id_regwrite && (id_rd != XZR);
    new_ent.rd    = id_rd;
  end

  // WB hit only matters when the regfile lacks write-before-read
  always_comb begin
    match_a = sb_hit(sb_ex, id_rs_a)
            | sb_hit(sb_mem, id_rs_a)
            | (!WB_BYPASS && sb_hit(sb_wb, id_rs_a));
    match_b = sb_hit(sb_ex, id_rs_b)
            | sb_hit(sb_mem, id_rs_b)
            | (!WB_BYPASS && sb_hit(sb_wb, id_rs_b));
  end

  assign hazard = id_valid &&
    ((id_rs_a_used && (id_rs_a != XZR) && match_a) ||
     (id_rs_b_used && (id_rs_b != XZR) && match_b));

  assign empty = !(sb_ex.valid || sb_mem.valid || sb_wb.valid);

  // A flush squashes both the ID issue and the EX instruction
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= flush ? '0 : sb_ex;
      sb_ex  <= (issue && !flush) ? new_ent : '0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: RAW stall, branch flush, drain/halt.
// Ports: ID operands, mem_branch_taken, halt_req -> PC/IFID/IDEX ctrl.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic             id_valid,
  input  logic [4:0]       id_rs_a,
  input  logic             id_rs_a_used,
  input  logic [4:0]       id_rs_b,
  input  logic             id_rs_b_used,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             mem_branch_taken,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state, next_state;
  logic   hazard, sb_empty;
  logic   run_like, flush, eff_haz, issue;

  assign run_like = (state == ST_RUN) || (state == ST_STALL);
  assign flush    = mem_branch_taken && (state != ST_HALTED);
  // ID hazard is irrelevant in a flush cycle: ID is squashed
  assign eff_haz  = hazard && !flush;
  assign issue    = id_valid && !hazard && run_like
                 && !mem_branch_taken;

  pipe_hazard_ctrl_scoreboard #(
    .WB_BYPASS(WB_BYPASS)
  ) u_sb (
    .CLK         (CLK),
    .resetl      (resetl),
    .flush       (flush),
    .issue       (issue),
    .id_valid    (id_valid),
    .id_rs_a     (id_rs_a),
    .id_rs_a_used(id_rs_a_used),
    .id_rs_b     (id_rs_b),
    .id_rs_b_used(id_rs_b_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .hazard      (hazard),
    .empty       (sb_empty)
  );

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state  <= ST_RUN;
      halted <= 1'b0;
    end else begin
      state  <= next_state;
      halted <= (next_state == ST_HALTED);
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_RUN, ST_STALL: begin
        if (halt_req)     next_state = ST_DRAIN;
        else if (eff_haz) next_state = ST_STALL;
        else              next_state = ST_RUN;
      end
      ST_DRAIN: begin
        if (!halt_req)
          next_state = ST_RUN;
        else if (sb_empty && !mem_branch_taken)
          next_state = ST_HALTED;
      end
      ST_HALTED: begin
        if (!halt_req) next_state = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_sel_branch = 1'b0;
    ifid_write    = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    exmem_flush   = 1'b0;
    if (flush) begin
      pc_write      = 1'b1;
      pc_sel_branch = 1'b1;
      ifid_write    = 1'b1;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      exmem_flush   = 1'b1;
    end else if (run_like && !hazard) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end else begin
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (eff_haz && run_like && (stall_cnt != '1))
        stall_cnt <= stall_cnt + ONE;
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances, WB_BYPASS=1/0,
// sharing stimulus; 4-bit counters so saturation is reachable.
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       resetl;
  logic       id_valid, id_rs_a_used, id_rs_b_used, id_regwrite;
  logic [4:0] id_rs_a, id_rs_b, id_rd;
  logic       mem_branch_taken, halt_req;

  logic          b_pcw, b_pcsel, b_ifw, b_iff, b_idb, b_exf, b_halt;
  logic [CW-1:0] b_scnt, b_fcnt;
  logic          n_pcw, n_pcsel, n_ifw, n_iff, n_idb, n_exf, n_halt;
  logic [CW-1:0] n_scnt, n_fcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(CW)) u_byp (
    .CLK(clk), .resetl(resetl), .id_valid(id_valid),
    .id_rs_a(id_rs_a), .id_rs_a_used(id_rs_a_used),
    .id_rs_b(id_rs_b), .id_rs_b_used(id_rs_b_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite),
    .mem_branch_taken(mem_branch_taken), .halt_req(halt_req),
    .pc_write(b_pcw), .pc_sel_branch(b_pcsel),
    .ifid_write(b_ifw), .ifid_flush(b_iff),
    .idex_bubble(b_idb), .exmem_flush(b_exf),
    .halted(b_halt), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  pipe_hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(CW)) u_nob (
    .CLK(clk), .resetl(resetl), .id_valid(id_valid),
    .id_rs_a(id_rs_a), .id_rs_a_used(id_rs_a_used),
    .id_rs_b(id_rs_b), .id_rs_b_used(id_rs_b_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite),
    .mem_branch_taken(mem_branch_taken), .halt_req(halt_req),
    .pc_write(n_pcw), .pc_sel_branch(n_pcsel),
    .ifid_write(n_ifw), .ifid_flush(n_iff),
    .idex_bubble(n_idb), .exmem_flush(n_exf),
    .halted(n_halt), .stall_cnt(n_scnt), .flush_cnt(n_fcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs_a = 0; id_rs_a_used = 0;
    id_rs_b = 0; id_rs_b_used = 0; id_rd = 0;
    id_regwrite = 0; mem_branch_taken = 0; halt_req = 0;
  endtask

  // ID holds a producer writing rd (no sources)
  task automatic prod(input logic [4:0] rd);
    idle();
    id_valid = 1; id_rd = rd; id_regwrite = 1;
  endtask

  // ID holds a non-writing consumer reading ra
  task automatic cons(input logic [4:0] ra);
    idle();
    id_valid = 1; id_rs_a = ra; id_rs_a_used = 1;
  endtask

  task automatic do_reset();
    idle();
    resetl = 0;
    tick(); tick();
    resetl = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (b_pcw !== 1'b1 || n_pcw !== 1'b1) begin
      errors++;
      $display("FAIL reset_pc_write: got %b/%b want 1/1", b_pcw, n_pcw);
    end
    checks++;
    if (b_halt !== 1'b0 || n_halt !== 1'b0) begin
      errors++;
      $display("FAIL reset_halted: got %b/%b want 0/0", b_halt, n_halt);
    end
    checks++;
    if (b_scnt !== 0 || b_fcnt !== 0 || n_scnt !== 0 || n_fcnt !== 0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d %0d %0d %0d want 0",
               b_scnt, b_fcnt, n_scnt, n_fcnt);
    end
  endtask

  // ADD X1 ; ADD X2,X1 : bypass stalls 2, no-bypass stalls 3
  task automatic test_raw_stall();
    do_reset();
    prod(5'd1); tick();
    cons(5'd1);
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++;
      if (b_pcw !== (c >= 3) || b_idb !== (c < 3)) begin
        errors++;
        $display("FAIL raw_byp_c%0d: got pcw=%b bub=%b want pcw=%b",
                 c, b_pcw, b_idb, c >= 3);
      end
      checks++;
      if (n_pcw !== (c >= 4) || n_idb !== (c < 4)) begin
        errors++;
        $display("FAIL raw_nob_c%0d: got pcw=%b bub=%b want pcw=%b",
                 c, n_pcw, n_idb, c >= 4);
      end
      tick();
    end
    idle(); tick();
    checks++;
    if (b_scnt !== 2 || n_scnt !== 3) begin
      errors++;
      $display("FAIL raw_stall_cnt: got %0d/%0d want 2/3", b_scnt, n_scnt);
    end
    // XZR producer and reader: never a hazard
    do_reset();
    prod(5'd31); tick();
    cons(5'd31);
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++;
      if (b_pcw !== 1'b1 || n_pcw !== 1'b1) begin
        errors++;
        $display("FAIL xzr_c%0d: got %b/%b want 1/1", c, b_pcw, n_pcw);
      end
      tick();
    end
    checks++;
    if (b_scnt !== 0 || n_scnt !== 0) begin
      errors++;
      $display("FAIL xzr_cnt: got %0d/%0d want 0/0", b_scnt, n_scnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    prod(5'd3); tick();
    cons(5'd3); mem_branch_taken = 1;
    #1;
    checks++;
    if ({b_pcw, b_pcsel, b_iff, b_idb, b_exf} !== 5'b11111 ||
        {n_pcw, n_pcsel, n_iff, n_idb, n_exf} !== 5'b11111) begin
      errors++;
      $display("FAIL flush_outs: got %b%b%b%b%b want 11111",
               b_pcw, b_pcsel, b_iff, b_idb, b_exf);
    end
    tick();
    checks++;
    if (b_fcnt !== 1 || n_fcnt !== 1 || b_scnt !== 0) begin
      errors++;
      $display("FAIL flush_cnt: got f=%0d/%0d s=%0d want 1/1 s=0",
               b_fcnt, n_fcnt, b_scnt);
    end
    // squashed X3 producer must no longer cause a hazard
    cons(5'd3);
    #1;
    checks++;
    if (b_pcw !== 1'b1 || n_pcw !== 1'b1 || b_pcsel !== 1'b0) begin
      errors++;
      $display("FAIL flush_sb_clear: got %b/%b sel=%b want 1/1 sel=0",
               b_pcw, n_pcw, b_pcsel);
    end
    tick();
  endtask

  task automatic test_halt_drain();
    int hc;
    do_reset();
    prod(5'd4); tick();
    prod(5'd5); tick();
    prod(5'd6); tick();
    idle(); halt_req = 1; tick();
    hc = 0;
    for (int c = 0; c < 6 && b_halt !== 1'b1; c++) begin
      #1;
      checks++;
      if (b_pcw !== 1'b0 || b_idb !== 1'b1) begin
        errors++;
        $display("FAIL drain_outs: got pcw=%b bub=%b want 0/1",
                 b_pcw, b_idb);
      end
      tick();
      hc++;
    end
    checks++;
    if (hc !== 3 || b_halt !== 1'b1 || n_halt !== 1'b1) begin
      errors++;
      $display("FAIL drain_len: got %0d cycles halted=%b/%b want 3 1/1",
               hc, b_halt, n_halt);
    end
    // stray branch in HALTED is ignored
    mem_branch_taken = 1;
    #1;
    checks++;
    if (b_pcsel !== 1'b0 || b_pcw !== 1'b0) begin
      errors++;
      $display("FAIL halted_branch: got sel=%b pcw=%b want 0/0",
               b_pcsel, b_pcw);
    end
    tick();
    checks++;
    if (b_fcnt !== 0 || b_halt !== 1'b1) begin
      errors++;
      $display("FAIL halted_hold: got f=%0d h=%b want 0/1", b_fcnt, b_halt);
    end
    cons(5'd4); halt_req = 0;
    #1;
    checks++;
    if (b_pcw !== 1'b0) begin
      errors++;
      $display("FAIL release_hold: got %b want 0", b_pcw);
    end
    tick();
    #1;
    checks++;
    if (b_halt !== 1'b0 || b_pcw !== 1'b1 || n_pcw !== 1'b1) begin
      errors++;
      $display("FAIL release_issue: got h=%b pcw=%b/%b want 0 1/1",
               b_halt, b_pcw, n_pcw);
    end
    tick();
  endtask

  task automatic run_pair();
    prod(5'd1); tick();
    cons(5'd1);
    for (int c = 0; c < 4; c++) tick();
    idle(); tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int p = 0; p < 7; p++) run_pair();
    checks++;
    if (b_scnt !== 4'd14) begin
      errors++;
      $display("FAIL sat_pre: got %0d want 14", b_scnt);
    end
    run_pair();
    checks++;
    if (b_scnt !== 4'd15 || n_scnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_hit: got %0d/%0d want 15/15", b_scnt, n_scnt);
    end
    run_pair();
    checks++;
    if (b_scnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold: got %0d want 15", b_scnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    prod(5'd1); tick();
    cons(5'd1); tick();
    resetl = 0; tick();
    resetl = 1;
    #1;
    checks++;
    if (b_pcw !== 1'b1 || n_pcw !== 1'b1 || b_scnt !== 0 || n_scnt !== 0) begin
      errors++;
      $display("FAIL rst_stall: got pcw=%b/%b cnt=%0d/%0d want 1/1 0/0",
               b_pcw, n_pcw, b_scnt, n_scnt);
    end
    tick();
  endtask

  initial begin
    idle();
    resetl = 0;
    test_reset();
    test_raw_stall();
    test_flush();
    test_halt_drain();
    test_saturation();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
